// File: rtl/cache_refill_controller_pkg.sv
// Shared types and line-geometry helpers for the data-cache refill controller.
package cache_refill_controller_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL,
    DONE
  } refill_state_t;

  function automatic int line_beats(input int width, input int block_size);
    return block_size / (width / 8);
  endfunction

  function automatic int beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Byte-offset bits within a line; invert to get the line-base mask.
  function automatic int unsigned line_mask(input int block_size);
    return block_size - 1;
  endfunction

endpackage

// File: rtl/cache_refill_controller_if.sv
// Beat-level request/acknowledge port between the refill controller and main memory.
interface cache_refill_controller_if #(
  parameter int Width = 32
);

  logic             Mem_Req;
  logic             Mem_WE;
  logic [Width-1:0] Mem_Address;
  logic [Width-1:0] Mem_WData;
  logic             Mem_Ack;
  logic [Width-1:0] Mem_RData;

  modport master (
    output Mem_Req, Mem_WE, Mem_Address, Mem_WData,
    input  Mem_Ack, Mem_RData
  );

  modport slave (
    input  Mem_Req, Mem_WE, Mem_Address, Mem_WData,
    output Mem_Ack, Mem_RData
  );

endinterface

// File: rtl/cache_refill_controller_line_beat_counter.sv
// Beat index within a cache line; shared by the writeback and fill phases, wraps after the last beat.
module cache_refill_controller_line_beat_counter #(
  parameter int Beats     = 4,
  parameter int BeatWidth = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  output logic [BeatWidth-1:0] beat,
  output logic [BeatWidth-1:0] beat_next,
  output logic                 last
);

  assign last = (beat == BeatWidth'(Beats - 1));

  // beat_next is exported so the registered memory request can be formed a cycle ahead.
  always_comb begin
    beat_next = beat;
    if (clear) begin
      beat_next = '0;
    end else if (enable) begin
      beat_next = last ? '0 : beat + BeatWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat <= '0;
    end else begin
      beat <= beat_next;
    end
  end

endmodule

// File: rtl/cache_refill_controller.sv
// Miss handler for the direct-mapped data cache: writes back a dirty victim, then refills the line
// beat-by-beat from main memory while holding the core stalled.
module cache_refill_controller
  import cache_refill_controller_pkg::*;
#(
  parameter  int Width     = 32,
  parameter  int BlockSize = 16,
  localparam int Beats     = line_beats(Width, BlockSize),
  localparam int BeatWidth = beat_width(Beats)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Miss,
  input  logic [Width-1:0]       MissAddress,
  input  logic                   VictimDirty,
  input  logic [Width-1:0]       VictimAddress,
  input  logic [BlockSize*8-1:0] VictimData,
  output logic                   Stall,
  cache_refill_controller_if.master mem,
  output logic                   Fill_EN,
  output logic [BeatWidth-1:0]   Fill_Beat,
  output logic [Width-1:0]       Fill_Data,
  output logic                   Fill_Done
);

  localparam int               BeatBytes  = Width / 8;
  localparam logic [Width-1:0] OffsetMask = Width'(line_mask(BlockSize));

  refill_state_t          state, state_next;
  logic [Width-1:0]       fill_base, fill_base_next;
  logic [Width-1:0]       victim_base, victim_base_next;
  logic [BlockSize*8-1:0] victim_data, victim_data_next;
  logic                   start;
  logic                   beat_en;
  logic                   beat_clear;
  logic                   beat_last;
  logic [BeatWidth-1:0]   beat, beat_next;
  logic                   ack;
  logic                   req_next;
  logic                   we_next;
  logic [Width-1:0]       addr_next;
  logic [Width-1:0]       wdata_next;

  assign ack = mem.Mem_Ack & mem.Mem_Req;

  cache_refill_controller_line_beat_counter #(
    .Beats     (Beats),
    .BeatWidth (BeatWidth)
  ) u_beat_counter (
    .clk       (clk),
    .reset     (reset),
    .enable    (beat_en),
    .clear     (beat_clear),
    .beat      (beat),
    .beat_next (beat_next),
    .last      (beat_last)
  );

  always_comb begin
    state_next = state;
    start      = 1'b0;
    beat_en    = 1'b0;
    beat_clear = 1'b0;
    unique case (state)
      IDLE: begin
        if (Miss) begin
          start      = 1'b1;
          beat_clear = 1'b1;
          state_next = VictimDirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        if (ack) begin
          beat_en = 1'b1;
          if (beat_last) state_next = FILL;
        end
      end
      FILL: begin
        if (ack) begin
          beat_en = 1'b1;
          if (beat_last) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The request registers look at next-cycle values so they are valid the cycle the state is entered.
  always_comb begin
    fill_base_next   = start ? (MissAddress & ~OffsetMask) : fill_base;
    victim_base_next = start ? (VictimAddress & ~OffsetMask) : victim_base;
    victim_data_next = start ? VictimData : victim_data;
    req_next         = (state_next == WRITEBACK) || (state_next == FILL);
    we_next          = (state_next == WRITEBACK);
    addr_next        = '0;
    wdata_next       = '0;
    if (req_next) begin
      addr_next = (we_next ? victim_base_next : fill_base_next)
                + Width'(beat_next) * Width'(BeatBytes);
    end
    if (we_next) begin
      wdata_next = victim_data_next[beat_next*Width +: Width];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      fill_base       <= '0;
      victim_base     <= '0;
      victim_data     <= '0;
      mem.Mem_Req     <= 1'b0;
      mem.Mem_WE      <= 1'b0;
      mem.Mem_Address <= '0;
      mem.Mem_WData   <= '0;
    end else begin
      state           <= state_next;
      fill_base       <= fill_base_next;
      victim_base     <= victim_base_next;
      victim_data     <= victim_data_next;
      mem.Mem_Req     <= req_next;
      mem.Mem_WE      <= we_next;
      mem.Mem_Address <= addr_next;
      mem.Mem_WData   <= wdata_next;
    end
  end

  // Stall is combinational so the core freezes in the very cycle the miss is raised.
  assign Stall     = Miss | (state != IDLE);
  assign Fill_EN   = (state == FILL) & mem.Mem_Ack;
  assign Fill_Beat = beat;
  assign Fill_Data = Fill_EN ? mem.Mem_RData : '0;
  assign Fill_Done = (state == DONE);

endmodule

// File: tb/tb_cache_refill_controller.sv
// Directed self-checking bench for cache_refill_controller (Width=32, BlockSize=16, 4 beats per line).
module tb_cache_refill_controller;

  logic         clk;
  logic         reset;
  logic         miss;
  logic [31:0]  missAddress;
  logic         victimDirty;
  logic [31:0]  victimAddress;
  logic [127:0] victimData;
  logic         stall;
  logic         fillEn;
  logic [1:0]   fillBeat;
  logic [31:0]  fillData;
  logic         fillDone;

  int checkCount = 0;
  int passCount  = 0;

  cache_refill_controller_if #(.Width(32)) memBus ();

  cache_refill_controller #(
    .Width     (32),
    .BlockSize (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Miss          (miss),
    .MissAddress   (missAddress),
    .VictimDirty   (victimDirty),
    .VictimAddress (victimAddress),
    .VictimData    (victimData),
    .Stall         (stall),
    .mem           (memBus),
    .Fill_EN       (fillEn),
    .Fill_Beat     (fillBeat),
    .Fill_Data     (fillData),
    .Fill_Done     (fillDone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
  task automatic applyStimulus(input logic rst, input logic m, input logic [31:0] mAddr,
                               input logic dirty, input logic [31:0] vAddr, input logic [127:0] vData,
                               input logic ack, input logic [31:0] rdata);
    @(negedge clk);
    reset            = rst;
    miss             = m;
    missAddress      = mAddr;
    victimDirty      = dirty;
    victimAddress    = vAddr;
    victimData       = vData;
    memBus.Mem_Ack   = ack;
    memBus.Mem_RData = rdata;
    #1;
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0000;
  endfunction

  task automatic runMiss(input string tag, input logic [31:0] mAddr, input logic dirty,
                         input logic [31:0] vAddr, input logic [127:0] vData,
                         input int waits, input int expStall);
    logic [31:0] fillBase;
    logic [31:0] victimBase;
    logic [31:0] addr;
    logic        ack;
    logic        isFill;
    int          stallCount;
    int          fillCount;
    fillBase   = mAddr & 32'hFFFF_FFF0;
    victimBase = vAddr & 32'hFFFF_FFF0;
    stallCount = 0;
    fillCount  = 0;

    applyStimulus(1'b0, 1'b1, mAddr, dirty, vAddr, vData, 1'b0, 32'h0);
    stallCount += int'(stall);
    checkOutput({tag, " miss-cycle Stall"}, 32'(stall), 32'd1);
    checkOutput({tag, " miss-cycle Mem_Req"}, 32'(memBus.Mem_Req), 32'd0);

    for (int phase = (dirty ? 0 : 1); phase < 2; phase++) begin
      for (int b = 0; b < 4; b++) begin
        for (int w = 0; w <= waits; w++) begin
          ack    = (w == waits);
          isFill = (phase == 1);
          addr   = (isFill ? fillBase : victimBase) + 32'(b * 4);
          applyStimulus(1'b0, 1'b1, mAddr, dirty, vAddr, vData, ack, memWord(addr));
          stallCount += int'(stall);
          fillCount  += int'(fillEn);
          checkOutput({tag, " Mem_Req"}, 32'(memBus.Mem_Req), 32'd1);
          checkOutput({tag, " Mem_WE"}, 32'(memBus.Mem_WE), 32'(!isFill));
          checkOutput({tag, " Mem_Address"}, memBus.Mem_Address, addr);
          if (!isFill) begin
            checkOutput({tag, " Mem_WData"}, memBus.Mem_WData, vData[b*32 +: 32]);
          end
          checkOutput({tag, " Fill_EN"}, 32'(fillEn), 32'(isFill && ack));
          if (isFill && ack) begin
            checkOutput({tag, " Fill_Beat"}, 32'(fillBeat), 32'(b));
            checkOutput({tag, " Fill_Data"}, fillData, memWord(addr));
          end
          checkOutput({tag, " Fill_Done early"}, 32'(fillDone), 32'd0);
        end
      end
    end

    applyStimulus(1'b0, 1'b1, mAddr, dirty, vAddr, vData, 1'b0, 32'h0);
    stallCount += int'(stall);
    checkOutput({tag, " Fill_Done pulse"}, 32'(fillDone), 32'd1);
    checkOutput({tag, " done Mem_Req"}, 32'(memBus.Mem_Req), 32'd0);
    checkOutput({tag, " done Fill_EN"}, 32'(fillEn), 32'd0);

    applyStimulus(1'b0, 1'b0, mAddr, 1'b0, vAddr, vData, 1'b0, 32'h0);
    checkOutput({tag, " idle Stall"}, 32'(stall), 32'd0);
    checkOutput({tag, " idle Fill_Done"}, 32'(fillDone), 32'd0);
    checkOutput({tag, " idle Mem_Req"}, 32'(memBus.Mem_Req), 32'd0);
    checkOutput({tag, " stall cycles"}, 32'(stallCount), 32'(expStall));
    checkOutput({tag, " fill pulses"}, 32'(fillCount), 32'd4);
  endtask

  initial begin
    reset            = 1'b1;
    miss             = 1'b0;
    missAddress      = '0;
    victimDirty      = 1'b0;
    victimAddress    = '0;
    victimData       = '0;
    memBus.Mem_Ack   = 1'b0;
    memBus.Mem_RData = '0;

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0);
    checkOutput("reset Stall", 32'(stall), 32'd0);
    checkOutput("reset Mem_Req", 32'(memBus.Mem_Req), 32'd0);
    checkOutput("reset Mem_WE", 32'(memBus.Mem_WE), 32'd0);
    checkOutput("reset Mem_Address", memBus.Mem_Address, 32'h0);
    checkOutput("reset Mem_WData", memBus.Mem_WData, 32'h0);
    checkOutput("reset Fill_EN", 32'(fillEn), 32'd0);
    checkOutput("reset Fill_Beat", 32'(fillBeat), 32'd0);
    checkOutput("reset Fill_Data", fillData, 32'h0);
    checkOutput("reset Fill_Done", 32'(fillDone), 32'd0);

    runMiss("clean", 32'h0000_1234, 1'b0, 32'h0000_0000, 128'h0, 0, 6);

    runMiss("dirty", 32'h0000_2048, 1'b1, 32'h0000_0A30,
            128'h0000_4444_0000_3333_0000_2222_0000_1111, 0, 10);

    runMiss("slow", 32'h0000_3010, 1'b1, 32'h0000_7A3C,
            128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF, 3, 34);

    // Acks with no outstanding request must not disturb the idle controller.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0, 1'b1, 32'h1234_5678);
      checkOutput("spurious Fill_EN", 32'(fillEn), 32'd0);
      checkOutput("spurious Fill_Data", fillData, 32'h0);
      checkOutput("spurious Mem_Req", 32'(memBus.Mem_Req), 32'd0);
      checkOutput("spurious Stall", 32'(stall), 32'd0);
      checkOutput("spurious Fill_Beat", 32'(fillBeat), 32'd0);
    end
    runMiss("after spurious", 32'h0000_4000, 1'b0, 32'h0, 128'h0, 0, 6);

    applyStimulus(1'b0, 1'b1, 32'h0000_5000, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_5000, 1'b0, 32'h0, 128'h0, 1'b1, 32'hAAAA_0000);
    checkOutput("abort beat0 Fill_Beat", 32'(fillBeat), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0000_5000, 1'b0, 32'h0, 128'h0, 1'b1, 32'hAAAA_0001);
    checkOutput("abort beat1 Fill_Beat", 32'(fillBeat), 32'd1);
    checkOutput("abort beat1 Fill_EN", 32'(fillEn), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0000_5000, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0);
    checkOutput("abort pre-reset Mem_Address", memBus.Mem_Address, 32'h0000_5008);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0);
    checkOutput("abort Mem_Req", 32'(memBus.Mem_Req), 32'd0);
    checkOutput("abort Stall", 32'(stall), 32'd0);
    checkOutput("abort Fill_Beat", 32'(fillBeat), 32'd0);
    checkOutput("abort Mem_Address", memBus.Mem_Address, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("abort Fill_Done", 32'(fillDone), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0, 1'b0, 32'h0);
    end
    runMiss("restart", 32'h0000_5000, 1'b0, 32'h0, 128'h0, 0, 6);

    runMiss("wrap", 32'hFFFF_FFF8, 1'b0, 32'h0, 128'h0, 0, 6);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
